// File: rtl/mfp_srec_word_packer.sv
// Packs SREC parser byte writes into word-size AHB-Lite writes, falling back to byte writes for partial words.
// Optional idle auto-flush is enabled by defining MFP_PACKER_TIMEOUT_EN.
module mfp_srec_word_packer #(
    parameter logic [3:0] HPROT_VAL      = 4'b0011,
    parameter int         CNT_W          = 16,
    parameter int         TIMEOUT_CYCLES = 1024
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             big_endian,
    input  logic [31:0]      write_address,
    input  logic [7:0]       write_byte,
    input  logic             write_enable,
    input  logic             flush,
    input  logic             HREADY,
    output logic [31:0]      HADDR,
    output logic [2:0]       HBURST,
    output logic             HMASTLOCK,
    output logic [3:0]       HPROT,
    output logic [2:0]       HSIZE,
    output logic [1:0]       HTRANS,
    output logic [31:0]      HWDATA,
    output logic             HWRITE,
    output logic             busy,
    output logic             overflow_error,
    output logic [CNT_W-1:0] xfer_count
);

    // Handshake: an address phase is accepted on any edge where HTRANS=NONSEQ and HREADY=1;
    // the following data phase completes on the first edge after that with HREADY=1.

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Accumulator
    logic [29:0]      acc_addr;
    logic [3:0][7:0]  acc_data;
    logic [3:0]       acc_mask;

    // Emitter: copy of the handed-off accumulator plus item cursor
    logic [29:0]      em_addr;
    logic [3:0][7:0]  em_data;
    logic             em_word;
    logic [1:0]       em_off;
    logic [3:0]       em_rem;

    logic [31:0]      haddr_q;
    logic [2:0]       hsize_q;
    logic [31:0]      hwdata_q;
    logic [CNT_W-1:0] xfer_q;
    logic             ovf_q;

    logic [1:0] wr_lane;
    logic [3:0] wr_onehot;
    logic       same_word;
    logic       lane_set;
    logic       acc_full;
    logic       acc_empty;
    logic       conflict;
    logic       last_item;
    logic       emitter_free;
    logic       flush_req;
    logic       handoff;
    logic       drop;
    logic       data_done;

    logic [1:0] new_off;
    logic [3:0] new_rem;
    logic [1:0] adv_off;
    logic [3:0] adv_rem;
    logic [31:0] word_data;

    function automatic logic [1:0] low_lane(input logic [3:0] m);
        logic [1:0] r;
        r = 2'd3;
        if (m[2]) r = 2'd2;
        if (m[1]) r = 2'd1;
        if (m[0]) r = 2'd0;
        return r;
    endfunction

    function automatic logic [3:0] lane_bit(input logic [1:0] l);
        return 4'b0001 << l;
    endfunction

    assign wr_lane   = write_address[1:0];
    assign wr_onehot = lane_bit(wr_lane);
    assign same_word = (write_address[31:2] == acc_addr);
    assign lane_set  = |(acc_mask & wr_onehot);
    assign acc_full  = (acc_mask == 4'hF);
    assign acc_empty = (acc_mask == 4'h0);
    assign conflict  = write_enable && !acc_empty && (!same_word || lane_set);

    assign last_item    = (em_rem == 4'h0);
    assign data_done    = (state == ST_DATA) && HREADY;
    assign emitter_free = (state == ST_IDLE) || (data_done && last_item);

`ifdef MFP_PACKER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt;
    logic            timeout_hit;

    assign timeout_hit = (to_cnt == TO_W'(TIMEOUT_CYCLES));
    assign flush_req   = flush || timeout_hit;

    // Saturates at the limit so a stalled emitter keeps the flush request pending until handoff.
    always_ff @(posedge clock) begin
        if (reset || write_enable || handoff) begin
            to_cnt <= '0;
        end else if (!acc_empty && !timeout_hit) begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end
`else
    assign flush_req = flush;
`endif

    // flush is only honoured on cycles without a byte write
    assign handoff = emitter_free &&
                     (conflict || (!write_enable && !acc_empty && (acc_full || flush_req)));
    assign drop    = conflict && !emitter_free;

    assign new_off = acc_full ? 2'd0 : low_lane(acc_mask);
    assign new_rem = acc_full ? 4'h0 : (acc_mask & ~lane_bit(new_off));
    assign adv_off = low_lane(em_rem);
    assign adv_rem = em_rem & ~lane_bit(adv_off);

    assign word_data = big_endian ? {em_data[0], em_data[1], em_data[2], em_data[3]}
                                  : {em_data[3], em_data[2], em_data[1], em_data[0]};

    // Accumulator update
    always_ff @(posedge clock) begin
        if (reset) begin
            acc_addr <= '0;
            acc_data <= '0;
            acc_mask <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (drop) begin
                ovf_q <= 1'b1;
            end
            if (write_enable && !drop) begin
                acc_addr          <= write_address[31:2];
                acc_data[wr_lane] <= write_byte;
                acc_mask          <= (conflict ? 4'h0 : acc_mask) | wr_onehot;
            end else if (handoff) begin
                acc_mask <= 4'h0;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (handoff) state_next = ST_ADDR;
            end
            ST_ADDR: begin
                if (HREADY) state_next = ST_DATA;
            end
            ST_DATA: begin
                if (HREADY) begin
                    if (!last_item || handoff) state_next = ST_ADDR;
                    else                       state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_IDLE;
            em_addr  <= '0;
            em_data  <= '0;
            em_word  <= 1'b0;
            em_off   <= 2'd0;
            em_rem   <= 4'h0;
            haddr_q  <= '0;
            hsize_q  <= 3'b000;
            hwdata_q <= '0;
            xfer_q   <= '0;
        end else begin
            state <= state_next;
            if (handoff) begin
                em_addr <= acc_addr;
                em_data <= acc_data;
                em_word <= acc_full;
                em_off  <= new_off;
                em_rem  <= new_rem;
                haddr_q <= {acc_addr, new_off};
                hsize_q <= acc_full ? 3'b010 : 3'b000;
            end else if (data_done && !last_item) begin
                em_off  <= adv_off;
                em_rem  <= adv_rem;
                haddr_q <= {em_addr, adv_off};
            end
            // Handoff never coincides with an accepted address phase, so em_* is stable here.
            if (state == ST_ADDR && HREADY) begin
                hwdata_q <= em_word ? word_data : {4{em_data[em_off]}};
            end
            if (data_done) begin
                xfer_q <= xfer_q + CNT_W'(1);
            end
        end
    end

    assign HADDR          = haddr_q;
    assign HBURST         = 3'b000;
    assign HMASTLOCK      = 1'b0;
    assign HPROT          = HPROT_VAL;
    assign HSIZE          = hsize_q;
    assign HTRANS         = (state == ST_ADDR) ? 2'b10 : 2'b00;
    assign HWDATA         = hwdata_q;
    assign HWRITE         = (state == ST_ADDR);
    assign busy           = !acc_empty || (state != ST_IDLE);
    assign overflow_error = ovf_q;
    assign xfer_count     = xfer_q;

endmodule
